// File: rtl/mcs4_ram_master_pkg.sv
// Shared MCS-4 bus types: phases, data characters, I/O-RAM opcodes,
// RAM master states and opcode classification helpers.
package mcs4;

  typedef logic [3:0] char_t;

  typedef enum logic [2:0] {
    A1, A2, A3, M1, M2, X1, X2, X3
  } instr_cyc_t;

  typedef enum logic [3:0] {
    WRM = 4'h0, WMP = 4'h1,
    WRR = 4'h2, WPM = 4'h3,
    WR0 = 4'h4, WR1 = 4'h5,
    WR2 = 4'h6, WR3 = 4'h7,
    SBM = 4'h8, RDM = 4'h9,
    RDR = 4'hA, ADM = 4'hB,
    RD0 = 4'hC, RD1 = 4'hD,
    RD2 = 4'hE, RD3 = 4'hF
  } ioram_opa_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRC  = 2'd1,
    IO   = 2'd2
  } ram_mst_state_t;

  function automatic logic opa_is_read(
    ioram_opa_t opa
  );
    logic r;
    case (opa)
      SBM, RDM, RDR, ADM,
      RD0, RD1, RD2, RD3: r = 1'b1;
      default:            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic opa_is_write(
    ioram_opa_t opa
  );
    logic w;
    case (opa)
      WRM, WMP, WRR, WPM,
      WR0, WR1, WR2, WR3: w = 1'b1;
      default:            w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mcs4_ram_master_if.sv
// Host request/response and MCS-4 bus signals of the RAM master.
interface mcs4_ram_master_if;
  import mcs4::*;

  logic       sync;
  logic       cm_ram;
  char_t      dbus_out;
  char_t      dbus_in;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_addr;
  ioram_opa_t req_opa;
  char_t      req_wdata;
  logic       rsp_valid;
  char_t      rsp_rdata;

  modport master (
    output sync,
    output cm_ram,
    output dbus_out,
    input  dbus_in,
    input  req_valid,
    output req_ready,
    input  req_addr,
    input  req_opa,
    input  req_wdata,
    output rsp_valid,
    output rsp_rdata
  );

  modport slave (
    input  sync,
    input  cm_ram,
    input  dbus_in,
    input  dbus_out,
    output req_valid,
    input  req_ready,
    output req_addr,
    output req_opa,
    output req_wdata,
    input  rsp_valid,
    input  rsp_rdata
  );

endinterface

// File: rtl/mcs4_ram_master_timing_gen.sv
// MCS-4 instruction cycle phase counter (A1..X3) and sync generator,
// shared by all bus masters.
module mcs4_timing_gen
  import mcs4::*;
(
    input  logic       clk,
    input  logic       rst,
    output instr_cyc_t phase,
    output logic       sync
);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= X3;
        end else begin
            phase <= instr_cyc_t'(phase + 3'd1);
        end
    end

    // Asserted straight away on rst so responders abort mid-cycle.
    assign sync = rst | (phase == X3);

endmodule

// File: rtl/mcs4_ram_master.sv
// MCS-4 4002 RAM bus initiator: one host request -> SRC + I/O cycle.
// Optional MCS4_SRC_SKIP_EN omits SRC when the address is unchanged.
module mcs4_ram_master
  import mcs4::*;
#(
    parameter bit BACK_TO_BACK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mcs4_ram_master_if.master bus
);

    instr_cyc_t     phase;
    ram_mst_state_t state;
    logic           at_x3;
    logic           can_start;
    logic           accept;
    logic           skip_src;
    logic [7:0]     addr_q;
    ioram_opa_t     opa_q;
    char_t          wdata_q;

    mcs4_timing_gen u_tgen (
        .clk   (clk),
        .rst   (rst),
        .phase (phase),
        .sync  (bus.sync)
    );

    assign at_x3 = (phase == X3);

    assign can_start = (state == IDLE)
                     || (BACK_TO_BACK && state == IO);

    assign bus.req_ready = !rst && at_x3 && can_start;
    assign accept = bus.req_ready && bus.req_valid;

`ifdef MCS4_SRC_SKIP_EN
    logic [7:0] last_addr;
    logic       last_vld;

    assign skip_src = last_vld
                    && (bus.req_addr == last_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_addr <= '0;
            last_vld  <= 1'b0;
        end else if (accept && !skip_src) begin
            last_addr <= bus.req_addr;
            last_vld  <= 1'b1;
        end
    end
`else
    assign skip_src = 1'b0;
`endif

    // Transitions only happen at the X3 boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            opa_q   <= WRM;
            wdata_q <= '0;
        end else if (at_x3) begin
            unique case (1'b1)
                accept: begin
                    state   <= skip_src ? IO : SRC;
                    addr_q  <= bus.req_addr;
                    opa_q   <= bus.req_opa;
                    wdata_q <= bus.req_wdata;
                end
                (state == SRC): state <= IO;
                default:        state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_rdata <= '0;
        end else if (state == IO && phase == X2) begin
            bus.rsp_rdata <= opa_is_read(opa_q)
                           ? bus.dbus_in : 4'h0;
        end
    end

    assign bus.rsp_valid = !rst && state == IO && at_x3;

    // cm_ram must stay low on IO X2 or responders relatch the address.
    always_comb begin
        bus.cm_ram   = 1'b0;
        bus.dbus_out = 4'h0;
        if (!rst) begin
            unique case (1'b1)
                (state == SRC && phase == X2): begin
                    bus.cm_ram   = 1'b1;
                    bus.dbus_out = addr_q[7:4];
                end
                (state == SRC && phase == X3): begin
                    bus.dbus_out = addr_q[3:0];
                end
                (state == IO && phase == M2): begin
                    bus.cm_ram   = 1'b1;
                    bus.dbus_out = char_t'(opa_q);
                end
                (state == IO && phase == X2): begin
                    bus.dbus_out = opa_is_write(opa_q)
                                 ? wdata_q : 4'h0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcs4_ram_master.sv
// Directed bench for mcs4_ram_master with a behavioural 4002 responder.
module tb_mcs4_ram_master;
  import mcs4::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcs4_ram_master_if bus ();
  mcs4_ram_master_if nb ();

  mcs4_ram_master #(.BACK_TO_BACK(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );
  mcs4_ram_master #(.BACK_TO_BACK(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .bus(nb.master)
  );

  assign nb.dbus_in = 4'h0;

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // 4002 responder model (all four chip ids)
  logic [2:0] mph = 3'd0;
  logic  src_hi = 1'b0;
  logic  io_act = 1'b0;
  char_t m_hi = 4'h0;
  char_t m_ch = 4'h0;
  char_t m_op = 4'h0;
  char_t rdv;
  char_t mem [256] = '{default: 4'h0};
  char_t stat [16][4] = '{default: '{default: 4'h0}};

  always @(posedge clk) begin
    if (rst) begin
      mph    <= 3'd0;
      src_hi <= 1'b0;
      io_act <= 1'b0;
    end else begin
      mph <= bus.sync ? 3'd0 : mph + 3'd1;
      if (mph == 3'd6 && bus.cm_ram) begin
        m_hi   <= bus.dbus_out;
        src_hi <= 1'b1;
      end else if (mph == 3'd7 && src_hi) begin
        m_ch   <= bus.dbus_out;
        src_hi <= 1'b0;
      end
      if (mph == 3'd4 && bus.cm_ram) begin
        m_op   <= bus.dbus_out;
        io_act <= 1'b1;
      end
      if (mph == 3'd6 && io_act) begin
        io_act <= 1'b0;
        if (m_op == 4'h0)
          mem[{m_hi, m_ch}] <= bus.dbus_out;
        else if (m_op[3:2] == 2'b01)
          stat[m_hi][m_op[1:0]] <= bus.dbus_out;
      end
    end
  end

  always_comb begin
    rdv = 4'h0;
    if (m_op == 4'h8 || m_op == 4'h9 || m_op == 4'hB)
      rdv = mem[{m_hi, m_ch}];
    else if (m_op[3:2] == 2'b11)
      rdv = stat[m_hi][m_op[1:0]];
  end

  assign bus.dbus_in =
    (mph == 3'd6 && io_act && m_op[3]) ? rdv : 4'h0;

  // expected SRC-skip tracking
  logic [7:0] t_last = 8'h00;
  bit         t_vld = 1'b0;
  int         exp_lat = 16;
  logic       cap_cm [0:16];
  char_t      cap_db [0:16];

  task automatic do_req(
    input  logic [7:0] a,
    input  logic [3:0] op,
    input  logic [3:0] wd,
    output int         lat,
    output logic [3:0] rd
  );
    int  n;
    bit  sk;
    lat = 0;
    rd  = 4'h0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_opa   = ioram_opa_t'(op);
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept", bus.req_ready, 1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    sk = 1'b0;
`ifdef MCS4_SRC_SKIP_EN
    sk = t_vld && (a == t_last);
`endif
    if (!sk) begin
      t_last = a;
      t_vld  = 1'b1;
    end
    exp_lat = sk ? 8 : 16;
    for (int i = 0; i <= 16; i++) begin
      cap_cm[i] = 1'b0;
      cap_db[i] = 4'h0;
    end
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 1) bus.req_valid = 1'b0;
      if (i <= 16) begin
        cap_cm[i] = bus.cm_ram;
        cap_db[i] = bus.dbus_out;
      end
      if (bus.rsp_valid) begin
        lat = i;
        rd  = bus.rsp_rdata;
        break;
      end
    end
    chk("latency", lat, exp_lat);
  endtask

  task automatic b2b(input bit sel, input int gap);
    int  acc = 0;
    int  nr = 0;
    int  ta0 = 0;
    int  tr [4] = '{0, 0, 0, 0};
    bit  upd = 1'b0;
    logic rv, rdy, vl;
    @(negedge clk);
    if (sel) begin
      nb.req_valid = 1'b1; nb.req_addr = 8'h40;
      nb.req_opa = WRM;   nb.req_wdata = 4'h0;
    end else begin
      bus.req_valid = 1'b1; bus.req_addr = 8'h40;
      bus.req_opa = WRM;   bus.req_wdata = 4'h0;
    end
    for (int t = 0; t < 200 && nr < 4; t++) begin
      if (upd) begin
        upd = 1'b0;
        if (sel) begin
          nb.req_valid = (acc < 4);
          nb.req_addr  = 8'h40 + 8'(acc);
        end else begin
          bus.req_valid = (acc < 4);
          bus.req_addr  = 8'h40 + 8'(acc);
        end
      end
      rv  = sel ? nb.rsp_valid : bus.rsp_valid;
      rdy = sel ? nb.req_ready : bus.req_ready;
      vl  = sel ? nb.req_valid : bus.req_valid;
      if (rv) begin
        tr[nr] = t;
        nr++;
      end
      if (vl && rdy) begin
        if (acc == 0) ta0 = t;
        acc++;
        upd = 1'b1;
      end
      @(negedge clk);
    end
    nb.req_valid  = 1'b0;
    bus.req_valid = 1'b0;
    if (!sel) begin
      t_last = 8'h43;
      t_vld  = 1'b1;
    end
    chk("b2b_count", nr, 4);
    chk("b2b_first", tr[0] - ta0, 16);
    for (int i = 1; i < 4; i++)
      chk("b2b_gap", tr[i] - tr[i-1], gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat;
    logic [3:0] rd;
    logic       bad;
    bus.req_valid = 1'b0; bus.req_addr = 8'h00;
    bus.req_opa = WRM;    bus.req_wdata = 4'h0;
    nb.req_valid = 1'b0;  nb.req_addr = 8'h00;
    nb.req_opa = WRM;     nb.req_wdata = 4'h0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sync", bus.sync, 1);
    chk("rst_cm_ram", bus.cm_ram, 0);
    chk("rst_dbus", bus.dbus_out, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    rst = 1'b0;

    bad = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      chk("idle_sync", bus.sync, (i % 8) == 7);
      chk("idle_ready", bus.req_ready, (i % 8) == 7);
      bad |= bus.cm_ram | (|bus.dbus_out)
           | bus.rsp_valid;
    end
    chk("idle_quiet", bad, 0);

    do_req(8'h25, 4'h0, 4'hA, lat, rd);
    chk("wrm_src_x2_cm", cap_cm[7], 1);
    chk("wrm_src_x2_db", cap_db[7], 4'h2);
    chk("wrm_src_x3_cm", cap_cm[8], 0);
    chk("wrm_src_x3_db", cap_db[8], 4'h5);
    chk("wrm_m2_cm", cap_cm[13], 1);
    chk("wrm_m2_opa", cap_db[13], 4'h0);
    chk("wrm_x2_cm", cap_cm[15], 0);
    chk("wrm_x2_data", cap_db[15], 4'hA);
    chk("wrm_rdata", rd, 4'h0);

    do_req(8'h25, 4'h9, 4'h0, lat, rd);
    chk("rdm_m2_cm", cap_cm[exp_lat-3], 1);
    chk("rdm_m2_opa", cap_db[exp_lat-3], 4'h9);
    chk("rdm_x2_db", cap_db[exp_lat-1], 4'h0);
    chk("rdm_rdata", rd, 4'hA);

    do_req(8'h70, 4'h6, 4'h3, lat, rd);
    chk("wr2_rdata", rd, 4'h0);
    do_req(8'h70, 4'hE, 4'h0, lat, rd);
    chk("rd2_rdata", rd, 4'h3);
    do_req(8'h30, 4'hE, 4'h0, lat, rd);
    chk("rd2_other_chip", rd, 4'h0);
    do_req(8'h70, 4'h9, 4'h0, lat, rd);
    chk("rdm_status_apart", rd, 4'h0);

    // reset during IO M2 of a read
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'h25;
    bus.req_opa   = RDM;
    for (int n = 0; n < 40 && !bus.req_ready; n++)
      @(negedge clk);
    chk("rst_test_accept", bus.req_ready, 1);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (i == 1) bus.req_valid = 1'b0;
    end
    chk("rst_test_m2_cm", bus.cm_ram, 1);
    rst = 1'b1;
    #1;
    chk("rst_sync_now", bus.sync, 1);
    bad = 1'b0;
    repeat (2) begin
      @(negedge clk);
      bad |= !bus.sync | bus.rsp_valid;
    end
    rst = 1'b0;
    t_vld = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bad |= bus.rsp_valid;
    end
    chk("rst_abandon", bad, 0);
    do_req(8'h25, 4'h9, 4'h0, lat, rd);
    chk("post_rst_rdata", rd, 4'hA);

    b2b(1'b0, 16);
    b2b(1'b1, 24);

`ifdef MCS4_SRC_SKIP_EN
    do_req(8'h25, 4'h9, 4'h0, lat, rd);
    chk("skip1_rdata", rd, 4'hA);
    do_req(8'h25, 4'h9, 4'h0, lat, rd);
    chk("skip2_rdata", rd, 4'hA);
    bad = 1'b0;
    for (int i = 1; i <= 8; i++)
      if (i != 5) bad |= cap_cm[i];
    chk("skip2_no_src", bad, 0);
    do_req(8'h26, 4'h9, 4'h0, lat, rd);
    chk("skip3_src_cm", cap_cm[7], 1);
    chk("skip3_src_db", cap_db[8], 4'h6);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
